// File: rtl/cpu_dbg_pkg.sv
// Shared opcodes, reply codes, FSM states and the status reply layout
// for the CPU debug command decoder.
package cpu_dbg_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;

  localparam logic [NIB_W-1:0] OP_RST      = 4'h0;
  localparam logic [NIB_W-1:0] OP_STEP     = 4'h1;
  localparam logic [NIB_W-1:0] OP_STEP_ON  = 4'h2;
  localparam logic [NIB_W-1:0] OP_STEP_OFF = 4'h3;
  localparam logic [NIB_W-1:0] OP_MSTEP    = 4'h4;
  localparam logic [NIB_W-1:0] OP_STATUS   = 4'h5;

  localparam logic [NIB_W-1:0]  RPL_OK_HI   = 4'h0;
  localparam logic [NIB_W-1:0]  RPL_TMO_HI  = 4'hE;
  localparam logic [NIB_W-1:0]  RPL_STAT_HI = 4'h8;
  localparam logic [BYTE_W-1:0] RPL_BAD     = 8'hFF;

  typedef enum logic [2:0] {
    IDLE, ARG, RST, STEP, WAITBUSY, SEND, DONE
  } state_t;

  typedef struct packed {
    logic [NIB_W-1:0] hi;
    logic             rsvd;
    logic             stepmode;
    logic             busy;
    logic             err;
  } status_t;

endpackage

// File: rtl/dbg_busy_timer.sv
// Saturating busy-cycle counter; expired rises once busy has been seen
// for 2^TMO_W-1 cycles since the last clr.
module dbg_busy_timer #(
  parameter int unsigned TMO_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (busy && !expired) begin
      cnt     <= cnt + TMO_W'(1);
      expired <= (cnt == CNT_MAX - TMO_W'(1));
    end
  end

endmodule

// File: rtl/cpu_dbg_ctl.sv
// Debug command decoder: turns received UART bytes into CPU reset/step
// controls and answers every accepted command with one reply byte.
module cpu_dbg_ctl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TMO_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] opcode,
  input  logic              en,
  input  logic              ctl_busy,
  output logic              ctl_rst,
  output logic              ctl_step,
  output logic              ctl_stepmode,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [BYTE_W-1:0] tx_data
);

  localparam int unsigned RW = $clog2(RST_CYCLES) + 1;

  state_t            state;
  logic [NIB_W-1:0]  cmd;
  logic [CNT_W-1:0]  count;
  logic [RW-1:0]     rst_cnt;
  logic [BYTE_W-1:0] reply;
  logic              last_err;
  logic              guard;
  logic              tmr_clr;
  logic              tmr_expired;
  status_t           status;

  // Timer restarts whenever WAITBUSY is (re)entered.
  assign tmr_clr = (state != WAITBUSY);

  dbg_busy_timer #(.TMO_W(TMO_W)) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .busy    (ctl_busy),
    .expired (tmr_expired)
  );

  always_comb begin
    status          = '0;
    status.hi       = RPL_STAT_HI;
    status.stepmode = ctl_stepmode;
    status.busy     = ctl_busy;
    status.err      = last_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd          <= '0;
      count        <= '0;
      rst_cnt      <= '0;
      reply        <= '0;
      last_err     <= 1'b0;
      guard        <= 1'b0;
      ctl_rst      <= 1'b0;
      ctl_step     <= 1'b0;
      ctl_stepmode <= 1'b0;
      tx_en        <= 1'b0;
      tx_data      <= '0;
    end else begin
      ctl_step <= 1'b0;
      tx_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (en && opcode[7:4] == 4'h0) begin
            cmd <= opcode[3:0];
            case (opcode[3:0])
              OP_RST: begin
                ctl_rst <= 1'b1;
                rst_cnt <= RW'(RST_CYCLES - 1);
                count   <= '0;
                state   <= RST;
              end
              OP_STEP: begin
                ctl_step <= 1'b1;
                count    <= CNT_W'(1);
                state    <= STEP;
              end
              OP_STEP_ON, OP_STEP_OFF: begin
                ctl_stepmode <= (opcode[3:0] == OP_STEP_ON);
                count        <= '0;
                guard        <= 1'b1;
                state        <= WAITBUSY;
              end
              OP_MSTEP: state <= ARG;
              OP_STATUS: begin
                reply <= status;
                state <= SEND;
              end
              default: begin
                reply <= RPL_BAD;
                state <= SEND;
              end
            endcase
          end
        end
        ARG: begin
          if (en) begin
            if (opcode == '0) begin
              reply <= {RPL_OK_HI, cmd};
              state <= SEND;
            end else if (!ctl_stepmode) begin
              reply    <= {RPL_TMO_HI, cmd};
              last_err <= 1'b1;
              state    <= SEND;
            end else begin
              count    <= CNT_W'(opcode);
              ctl_step <= 1'b1;
              state    <= STEP;
            end
          end
        end
        RST: begin
          if (rst_cnt == '0) begin
            ctl_rst <= 1'b0;
            guard   <= 1'b1;
            state   <= WAITBUSY;
          end else begin
            rst_cnt <= rst_cnt - RW'(1);
          end
        end
        STEP: begin
          guard <= 1'b1;
          state <= WAITBUSY;
        end
        WAITBUSY: begin
          // First cycle after entry ignores ctl_busy so the CPU can raise it.
          if (guard) begin
            guard <= 1'b0;
          end else if (!ctl_busy) begin
            if (count > CNT_W'(1)) begin
              count    <= count - CNT_W'(1);
              ctl_step <= 1'b1;
              state    <= STEP;
            end else begin
              count    <= '0;
              reply    <= {RPL_OK_HI, cmd};
              last_err <= 1'b0;
              state    <= SEND;
            end
          end else if (tmr_expired) begin
            count    <= '0;
            reply    <= {RPL_TMO_HI, cmd};
            last_err <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= reply;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_dbg_ctl.md
Name: cpu_dbg_ctl

Overview:
- Command decoder between the UART RX/TX byte path and the CPU debug controls: reset, single step, step-mode on/off.
- Adds multi-step bursts with a second argument byte, a status query, busy-timeout detection and error replies.
- Sits between the rx byte strobe and the tx byte port.
- Drives ctl_rst, ctl_step and ctl_stepmode into the CPU core.
- Sends exactly one reply byte for every accepted command.

Parameters:
- CNT_W, 8: width of the multi-step count argument. Fixed at 8 while the count travels in one byte.
- RST_CYCLES, 4: width of the ctl_rst pulse in clk cycles, ≥1.
- TMO_W, 16: busy-timeout counter width. Timeout fires after 2^TMO_W−1 cycles of ctl_busy high.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset.
- opcode, in, 8: received byte, valid when en=1.
- en, in, 1: one-cycle strobe marking a new byte.
- ctl_busy, in, 1: CPU is executing or resetting.
- ctl_rst, out, 1: CPU reset, active high.
- ctl_step, out, 1: one-cycle step pulse.
- ctl_stepmode, out, 1: step mode enable, level.
- tx_busy, in, 1: transmitter busy.
- tx_en, out, 1: one-cycle send strobe.
- tx_data, out, 8: reply byte, held stable from tx_en until the next reply.

Interface rule (already decided): one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- Reset values: ctl_rst=0, ctl_step=0, ctl_stepmode=0, tx_en=0, tx_data=8'h00, last_err=0, state=IDLE, step counter=0.
- Reset asserted mid-operation aborts everything; no reply is sent.
- Command bytes: only opcode[7:4]==4'h0 are commands. Any other byte seen in IDLE is ignored and gets no reply.
- 4'h0 (reset): ctl_rst=1 for RST_CYCLES cycles, then go to WAITBUSY.
- 4'h1 (step): ctl_step=1 for one cycle; go to WAITBUSY with count=1.
- 4'h2 / 4'h3 (step on / off): set / clear ctl_stepmode on the next clock edge, then go to WAITBUSY.
- 4'h4 (multi-step): go to ARG; the next byte with en=1 is count N, taken as a raw 8-bit value.
- 4'h5 (status): go to SEND with reply {4'h8, 1'b0, ctl_stepmode, ctl_busy, last_err}, sampled in the accept cycle.
- 4'h6..4'hF: go to SEND with reply 8'hFF.
- States: IDLE, ARG, RST, STEP, WAITBUSY, SEND, DONE.
- ARG: waits indefinitely; no timeout.
  - N==0: reply 8'h04, no pulse.
  - ctl_stepmode==0: reply 8'hE4, no pulse, last_err=1.
  - Otherwise: count=N, go to STEP.
- STEP: ctl_step=1 for exactly one cycle, then WAITBUSY.
- WAITBUSY:
  - ctl_busy is not sampled in the first cycle after entry (guard cycle).
  - From the second cycle, when ctl_busy==0: decrement count. If count is still nonzero, go to STEP (consecutive pulses are at least 3 cycles apart). Otherwise reply {4'h0, cmd}, clear last_err, go to SEND.
  - Timer runs while ctl_busy==1 and clears on each state entry. If it reaches 2^TMO_W−1: reply {4'hE, cmd}, last_err=1, abandon remaining steps, go to SEND.
- SEND: wait for tx_busy==0, then tx_en=1 for one cycle with tx_data valid in that same cycle. Go to DONE.
- DONE: tx_en=0, go to IDLE. Total reply latency ≥2 cycles after the completion condition.
- Status reply 8'h8x is sent without waiting on ctl_busy.
- en outside IDLE/ARG: byte dropped, no queueing.
- en in IDLE and tx_busy high: the command is still accepted; only the reply waits.
- cmd is the low nibble latched at accept. Counters do not wrap: count stops at 0, timer saturates.

Decomposition:
- Package cpu_dbg_pkg holds:
  - opcode constants OP_RST..OP_STATUS;
  - reply constants RPL_OK_HI=4'h0, RPL_TMO_HI=4'hE, RPL_BAD=8'hFF, RPL_STAT_HI=4'h8;
  - the state enum.
- One sub-module, dbg_busy_timer (TMO_W): inputs clr and busy, output expired. Clears on clr, counts while busy, saturates.

Test Plan:
- Send 8'h00 with ctl_busy low → ctl_rst high exactly 4 cycles; single tx_en with 8'h00; tx_busy held 5 cycles delays tx_en by 5 cycles.
- Send 8'h02, then 8'h04, 8'h03, with a model returning ctl_busy=1 for 2 cycles per step → ctl_stepmode=1, replies 8'h02 and 8'h04, exactly 3 ctl_step pulses each ≥3 cycles apart.
- Send 8'h04, 8'h05 with ctl_stepmode=0 → no ctl_step, reply 8'hE4; a following 8'h05 → reply 8'h81.
- With TMO_W=4 and ctl_busy stuck at 1, send 8'h01 → one pulse, reply 8'hE1 after 15 busy cycles; later 8'h05 → 8'h83.
- Send 8'h07 → reply 8'hFF; send 8'h35 → no reply; send en during WAITBUSY → ignored, one reply only.
- Assert rst_n=0 mid multi-step (count 200) → all outputs return to reset values next cycle; no tx_en afterwards.
